apb_gpio_bank: RTL and testbench



---
 rtl/apb_gpio_bank_if.sv | 22 ++
 rtl/apb_gpio_bank.sv | 142 ++++++++++++++
 tb/tb_apb_gpio_bank.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_bank_if.sv
// APB slave-side bus bundle for the GPIO bank controller.
// The slave modport drives read data, ready and error back to the bus master.
interface apb_gpio_bank_if;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    modport master (
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/apb_gpio_bank.sv
// APB GPIO controller: NUM_PORTS banks of PORT_WIDTH pins with synchronised inputs,
// atomic set/clear of outputs, and per-pin edge interrupts with write-1-to-clear status.
module apb_gpio_bank #(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            apb_pclk,
    input  logic                            apb_prst,
    apb_gpio_bank_if.slave                  apb,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_i,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_o,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
    output logic                            irq
);
    localparam int W = NUM_PORTS * PORT_WIDTH;

    logic [W-1:0]            oe_q, oe_d, out_q, out_d;
    logic [W-1:0]            rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [W-1:0]            stat_q, stat_d, hist_q, hist_d;
    logic [W-1:0]            sync_q [SYNC_STAGES];
    logic [W-1:0]            sync_d [SYNC_STAGES];
    logic [31:0]             prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;

    logic [11:0]             addr_off;
    logic [6:0]              bank_idx;
    logic [2:0]              reg_idx;
    logic                    hit, err, wr_en;
    logic [31:0]             rd_data;
    logic [PORT_WIDTH-1:0]   wdata;
    logic [W-1:0]            sync_last, edge_set, w1c_mask;
    logic                    unused_bits;

    // Banks start at 0x040 on a 0x20 stride, so the offset's upper bits give the bank.
    assign addr_off    = apb.apb_paddr[11:0] - 12'h040;
    assign bank_idx    = addr_off[11:5];
    assign reg_idx     = addr_off[4:2];
    assign hit         = (apb.apb_paddr[11:0] >= 12'h040) && (int'(bank_idx) < NUM_PORTS);
    assign err         = !hit || (apb.apb_pwrite && reg_idx == 3'd2);
    assign wr_en       = apb.apb_psel && apb.apb_penable && apb.apb_pwrite && !err;
    assign wdata       = apb.apb_pwdata[PORT_WIDTH-1:0];
    assign unused_bits = ^{apb.apb_paddr[31:12], addr_off[1:0], apb.apb_pwdata};

    always_comb begin
        sync_last = sync_q[SYNC_STAGES-1];
        edge_set  = (sync_last & ~hist_q & rise_en_q) | (~sync_last & hist_q & fall_en_q);
        hist_d    = sync_last;
        sync_d[0] = gpio_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end

        oe_d      = oe_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_mask  = '0;
        rd_data   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hit && int'(bank_idx) == p) begin
                case (reg_idx)
                    3'd0: begin
                        rd_data = 32'(oe_q[p*PORT_WIDTH +: PORT_WIDTH]);
                        if (wr_en) oe_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                    end
                    3'd1: begin
                        rd_data = 32'(out_q[p*PORT_WIDTH +: PORT_WIDTH]);
                        if (wr_en) out_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                    end
                    3'd2: rd_data = 32'(sync_last[p*PORT_WIDTH +: PORT_WIDTH]);
                    3'd3: begin
                        if (wr_en) out_d[p*PORT_WIDTH +: PORT_WIDTH] =
                            out_q[p*PORT_WIDTH +: PORT_WIDTH] | wdata;
                    end
                    3'd4: begin
                        if (wr_en) out_d[p*PORT_WIDTH +: PORT_WIDTH] =
                            out_q[p*PORT_WIDTH +: PORT_WIDTH] & ~wdata;
                    end
                    3'd5: begin
                        rd_data = 32'(rise_en_q[p*PORT_WIDTH +: PORT_WIDTH]);
                        if (wr_en) rise_en_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                    end
                    3'd6: begin
                        rd_data = 32'(fall_en_q[p*PORT_WIDTH +: PORT_WIDTH]);
                        if (wr_en) fall_en_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                    end
                    3'd7: begin
                        rd_data = 32'(stat_q[p*PORT_WIDTH +: PORT_WIDTH]);
                        if (wr_en) w1c_mask[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                    end
                endcase
            end
        end

        // A new edge on the same cycle as a W1C keeps the bit set.
        stat_d = (stat_q & ~w1c_mask) | edge_set;

        // Response is captured in the setup phase and held through the access phase.
        if (apb.apb_psel && !apb.apb_penable) begin
            prdata_d  = apb.apb_pwrite ? 32'h0 : rd_data;
            pslverr_d = err;
        end else if (apb.apb_psel) begin
            prdata_d  = prdata_q;
            pslverr_d = pslverr_q;
        end else begin
            prdata_d  = 32'h0;
            pslverr_d = 1'b0;
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            oe_q      <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            hist_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            oe_q      <= oe_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            hist_q    <= hist_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
        end
    end

    assign apb.apb_prdata  = prdata_q;
    assign apb.apb_pslverr = pslverr_q;
    assign apb.apb_pready  = 1'b1;
    assign gpio_o          = out_q;
    assign gpio_oe         = oe_q;
    assign irq             = |stat_q;
endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed bench for apb_gpio_bank: a default 2x32 instance plus a 1x8 instance
// sharing one APB driver, selected by tgt.
module tb_apb_gpio_bank;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst8 = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, tgt = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [63:0] gpio_i0 = '0;
    logic [63:0] gpio_o0, gpio_oe0;
    logic        irq0;
    logic [7:0]  gpio_i8 = '0;
    logic [7:0]  gpio_o8, gpio_oe8;
    logic        irq8;
    logic [31:0] rdata;
    logic        slverr;
    logic [63:0] o_acc;

    apb_gpio_bank_if bus0();
    apb_gpio_bank_if bus8();

    assign bus0.apb_psel    = psel && !tgt;
    assign bus0.apb_penable = penable;
    assign bus0.apb_pwrite  = pwrite;
    assign bus0.apb_paddr   = paddr;
    assign bus0.apb_pwdata  = pwdata;
    assign bus8.apb_psel    = psel && tgt;
    assign bus8.apb_penable = penable;
    assign bus8.apb_pwrite  = pwrite;
    assign bus8.apb_paddr   = paddr;
    assign bus8.apb_pwdata  = pwdata;
    assign rdata  = tgt ? bus8.apb_prdata  : bus0.apb_prdata;
    assign slverr = tgt ? bus8.apb_pslverr : bus0.apb_pslverr;

    apb_gpio_bank dut0 (
        .apb_pclk(clk), .apb_prst(rst0), .apb(bus0),
        .gpio_i(gpio_i0), .gpio_o(gpio_o0), .gpio_oe(gpio_oe0), .irq(irq0)
    );

    apb_gpio_bank #(.NUM_PORTS(1), .PORT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .apb_pclk(clk), .apb_prst(rst8), .apb(bus8),
        .gpio_i(gpio_i8), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_rd(input logic t, input logic [11:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {20'h0, a};
        @(posedge clk); #1;
        d = rdata; e = slverr; penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic t, input logic [11:0] a, input logic [31:0] v, output logic e);
        @(posedge clk); #1;
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {20'h0, a}; pwdata = v;
        @(posedge clk); #1;
        e = slverr; o_acc = gpio_o0; penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    logic [11:0] a;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_gpio_o", gpio_o0, 64'h0);
        check_val("rst_gpio_oe", gpio_oe0, 64'h0);
        check_val("rst_irq", {63'h0, irq0}, 64'h0);
        check_val("rst_prdata", {32'h0, bus0.apb_prdata}, 64'h0);
        check_val("rst_pslverr", {63'h0, bus0.apb_pslverr}, 64'h0);
        check_val("rst_pready", {63'h0, bus0.apb_pready}, 64'h1);
        rst0 = 1'b0; rst8 = 1'b0;

        // Every register of both banks reads zero after reset
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
                a = 12'h040 + 12'(32 * b) + 12'(4 * r);
                apb_rd(1'b0, a, d, e);
                check_val($sformatf("rst_rd_%0h", a), {32'h0, d}, 64'h0);
                check_val($sformatf("rst_err_%0h", a), {63'h0, e}, 64'h0);
            end
        end

        // Bank1 output path, each update on its write edge
        apb_wr(1'b0, 12'h060, 32'hFFFF_FFFF, e);
        check_val("oe_b1", gpio_oe0, 64'hFFFF_FFFF_0000_0000);
        apb_wr(1'b0, 12'h064, 32'h0000_00F0, e);
        check_val("out_before_edge", o_acc, 64'h0);
        check_val("out_wr", gpio_o0, 64'h0000_00F0_0000_0000);
        apb_wr(1'b0, 12'h06C, 32'h0000_000F, e);
        check_val("set_before_edge", o_acc, 64'h0000_00F0_0000_0000);
        check_val("out_set", gpio_o0, 64'h0000_00FF_0000_0000);
        apb_wr(1'b0, 12'h070, 32'h0000_0030, e);
        check_val("out_clr", gpio_o0, 64'h0000_00CF_0000_0000);
        apb_rd(1'b0, 12'h064, d, e);
        check_val("out_rd", {32'h0, d}, 64'hCF);

        // Bank0 edge interrupts: pin1 starts high with no rise enabled
        gpio_i0[1] = 1'b1;
        repeat (4) @(posedge clk);
        apb_wr(1'b0, 12'h054, 32'h1, e);
        apb_wr(1'b0, 12'h058, 32'h2, e);
        @(posedge clk); #1;
        gpio_i0[0] = 1'b1;
        @(posedge clk); #1;
        check_val("irq_e1", {63'h0, irq0}, 64'h0);
        @(posedge clk); #1;
        check_val("irq_e2", {63'h0, irq0}, 64'h0);
        @(posedge clk); #1;
        check_val("irq_e3", {63'h0, irq0}, 64'h1);
        apb_rd(1'b0, 12'h05C, d, e);
        check_val("stat_rise0", {32'h0, d}, 64'h1);
        gpio_i0[1] = 1'b0;
        repeat (4) @(posedge clk);
        apb_rd(1'b0, 12'h05C, d, e);
        check_val("stat_fall1", {32'h0, d}, 64'h3);
        gpio_i0[1] = 1'b1;
        repeat (4) @(posedge clk);
        apb_rd(1'b0, 12'h05C, d, e);
        check_val("stat_rise1_ign", {32'h0, d}, 64'h3);

        // W1C colliding with a fresh rise on pin0: set wins
        gpio_i0[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gpio_i0[0] = 1'b1;
        apb_wr(1'b0, 12'h05C, 32'h1, e);
        check_val("w1c_race_irq", {63'h0, irq0}, 64'h1);
        apb_rd(1'b0, 12'h05C, d, e);
        check_val("w1c_race_stat", {32'h0, d}, 64'h3);
        apb_wr(1'b0, 12'h05C, 32'h3, e);
        check_val("w1c_irq_clr", {63'h0, irq0}, 64'h0);
        apb_rd(1'b0, 12'h05C, d, e);
        check_val("w1c_stat_clr", {32'h0, d}, 64'h0);

        // Error responses
        apb_rd(1'b0, 12'h080, d, e);
        check_val("bank2_err", {63'h0, e}, 64'h1);
        check_val("bank2_data", {32'h0, d}, 64'h0);
        apb_rd(1'b0, 12'h03C, d, e);
        check_val("low_err", {63'h0, e}, 64'h1);
        apb_wr(1'b0, 12'h048, 32'hFFFF_FFFF, e);
        check_val("wr_in_err", {63'h0, e}, 64'h1);
        apb_rd(1'b0, 12'h048, d, e);
        check_val("in_rd_err", {63'h0, e}, 64'h0);
        check_val("in_rd", {32'h0, d}, 64'h3);
        @(posedge clk); #1;
        check_val("prdata_idle", {32'h0, rdata}, 64'h0);
        apb_rd(1'b0, 12'h04C, d, e);
        check_val("set_rd", {32'h0, d}, 64'h0);
        check_val("set_rd_err", {63'h0, e}, 64'h0);

        // 8-bit build: upper bits dropped
        apb_wr(1'b1, 12'h044, 32'hFFFF_FFFF, e);
        check_val("w8_gpio_o", {56'h0, gpio_o8}, 64'hFF);
        apb_rd(1'b1, 12'h044, d, e);
        check_val("w8_out_rd", {32'h0, d}, 64'hFF);

        // Reset during the access phase of an OE write
        @(posedge clk); #1;
        tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h040; pwdata = 32'hFF;
        @(posedge clk); #1;
        penable = 1'b1; rst8 = 1'b1;
        @(posedge clk); #1;
        check_val("rstmid_oe", {56'h0, gpio_oe8}, 64'h0);
        check_val("rstmid_o", {56'h0, gpio_o8}, 64'h0);
        check_val("rstmid_err", {63'h0, slverr}, 64'h0);
        check_val("rstmid_ready", {63'h0, bus8.apb_pready}, 64'h1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst8 = 1'b0;
        apb_rd(1'b1, 12'h040, d, e);
        check_val("rstmid_oe_rd", {32'h0, d}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
